// File: rtl/m68k_freerun_checker.sv
// Freerun address-sequence checker for m68k bring-up: holds CPU reset, tracks bus cycles, reports mismatches to the AVR UART.
// Optional macro FREERUN_CHK_EXPECTED_EN adds the expected address to each report frame.
module m68k_freerun_checker #(
    parameter int ADDR_W         = 24,
    parameter int STRIDE         = 2,
    parameter int SKIP_READS     = 4,
    parameter int STARTUP_W      = 24,
    parameter int RESTART_ON_ERR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              as_s,
    input  logic [ADDR_W-1:0] addr_s,
    input  logic              bus_rst_n,
    output logic              cpu_reset,
    output logic              err,
    output logic [15:0]       err_count,
    output logic              err_dropped,
    output logic [7:0]        led_addr,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    input  logic              tx_busy
);
    localparam int NB    = (ADDR_W + 7) / 8;
    localparam int PAD_W = NB * 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int LANES = 1 << IDX_W;
    localparam logic [ADDR_W-1:0] SKIP_LAST = ADDR_W'((SKIP_READS - 1) * STRIDE);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(STRIDE);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NB - 1);

`ifdef FREERUN_CHK_EXPECTED_EN
    typedef enum logic [2:0] {S_IDLE, S_TAG, S_RX, S_EXP, S_EOL} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_TAG, S_RX, S_EOL} state_t;
`endif

    state_t             state_q, state_d;
    logic [STARTUP_W-1:0] cnt_q, cnt_d;
    logic [STARTUP_W:0] cnt_sum;
    logic               cpu_reset_q, cpu_reset_d;
    logic               as_q;
    logic [ADDR_W-1:0]  exp_q, exp_d;
    logic               started_q, started_d;
    logic               err_q, err_d;
    logic               rpt_start_q, rpt_start_d;
    logic [15:0]        err_count_q, err_count_d;
    logic               err_dropped_q, err_dropped_d;
    logic [7:0]         led_addr_q, led_addr_d;
    logic [ADDR_W-1:0]  rx_addr_q, rx_addr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               new_tx_data_q, new_tx_data_d;
    logic               rise, fall, mismatch, report_free;
    logic [7:0]         cur_byte;
    logic [PAD_W-1:0]   rx_pad;
    logic [7:0]         rx_lane [LANES];
`ifdef FREERUN_CHK_EXPECTED_EN
    logic [ADDR_W-1:0]  exp_addr_q, exp_addr_d;
    logic [PAD_W-1:0]   exp_pad;
    logic [7:0]         exp_lane [LANES];
    assign exp_pad = PAD_W'(exp_addr_q);
`endif

    assign rise    = as_s & ~as_q;
    assign fall    = ~as_s & as_q;
    assign cnt_sum = {1'b0, cnt_q} + {{STARTUP_W{1'b0}}, 1'b1};
    assign rx_pad  = PAD_W'(rx_addr_q);

    // Byte lanes in transmit order: lane 0 is the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi < NB) begin : g_used
                assign rx_lane[gi] = rx_pad[(NB-1-gi)*8 +: 8];
`ifdef FREERUN_CHK_EXPECTED_EN
                assign exp_lane[gi] = exp_pad[(NB-1-gi)*8 +: 8];
`endif
            end else begin : g_pad
                assign rx_lane[gi] = 8'h00;
`ifdef FREERUN_CHK_EXPECTED_EN
                assign exp_lane[gi] = 8'h00;
`endif
            end
        end
    endgenerate

    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            S_TAG:   cur_byte = 8'h45;
            S_RX:    cur_byte = rx_lane[idx_q];
`ifdef FREERUN_CHK_EXPECTED_EN
            S_EXP:   cur_byte = exp_lane[idx_q];
`endif
            S_EOL:   cur_byte = 8'h0A;
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        cpu_reset_d   = cpu_reset_q;
        exp_d         = exp_q;
        started_d     = started_q;
        err_count_d   = err_count_q;
        err_dropped_d = err_dropped_q;
        led_addr_d    = led_addr_q;
        rx_addr_d     = rx_addr_q;
        state_d       = state_q;
        idx_d         = idx_q;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;
`ifdef FREERUN_CHK_EXPECTED_EN
        exp_addr_d    = exp_addr_q;
`endif

        if (cpu_reset_q) begin
            cnt_d = cnt_sum[STARTUP_W-1:0];
            if (cnt_sum[STARTUP_W]) cpu_reset_d = 1'b0;
        end
        if (RESTART_ON_ERR != 0 && err_q) begin
            cnt_d       = '0;
            cpu_reset_d = 1'b1;
        end

        if (!bus_rst_n) begin
            exp_d     = '0;
            started_d = 1'b0;
        end else if (fall) begin
            if (!started_q && exp_q == SKIP_LAST) begin
                exp_d     = '0;
                started_d = 1'b1;
            end else begin
                exp_d = exp_q + STEP;
            end
        end

        // A report is free to start only if none is running or already launched.
        mismatch    = rise & bus_rst_n & (addr_s != exp_q);
        report_free = (state_q == S_IDLE) && !(err_q && rpt_start_q);
        err_d       = mismatch;
        rpt_start_d = mismatch & report_free;
        if (mismatch && report_free) begin
            rx_addr_d = addr_s;
`ifdef FREERUN_CHK_EXPECTED_EN
            exp_addr_d = exp_q;
`endif
        end
        if (mismatch && !report_free) err_dropped_d = 1'b1;
        if (rise) led_addr_d = addr_s[ADDR_W-1 -: 8];
        if (err_q && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;

        if (state_q == S_IDLE) begin
            if (err_q && rpt_start_q) begin
                state_d = S_TAG;
                idx_d   = '0;
            end
        end else if (!tx_busy && !new_tx_data_q) begin
            new_tx_data_d = 1'b1;
            tx_data_d     = cur_byte;
            case (state_q)
                S_TAG: begin
                    state_d = S_RX;
                    idx_d   = '0;
                end
                S_RX: begin
                    if (idx_q == LAST_IDX) begin
`ifdef FREERUN_CHK_EXPECTED_EN
                        state_d = S_EXP;
                        idx_d   = '0;
`else
                        state_d = S_EOL;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
`ifdef FREERUN_CHK_EXPECTED_EN
                S_EXP: begin
                    if (idx_q == LAST_IDX) state_d = S_EOL;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cpu_reset_q   <= 1'b1;
            as_q          <= 1'b0;
            exp_q         <= '0;
            started_q     <= 1'b0;
            err_q         <= 1'b0;
            rpt_start_q   <= 1'b0;
            err_count_q   <= '0;
            err_dropped_q <= 1'b0;
            led_addr_q    <= '0;
            rx_addr_q     <= '0;
            idx_q         <= '0;
            tx_data_q     <= '0;
            new_tx_data_q <= 1'b0;
`ifdef FREERUN_CHK_EXPECTED_EN
            exp_addr_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cpu_reset_q   <= cpu_reset_d;
            as_q          <= as_s;
            exp_q         <= exp_d;
            started_q     <= started_d;
            err_q         <= err_d;
            rpt_start_q   <= rpt_start_d;
            err_count_q   <= err_count_d;
            err_dropped_q <= err_dropped_d;
            led_addr_q    <= led_addr_d;
            rx_addr_q     <= rx_addr_d;
            idx_q         <= idx_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
`ifdef FREERUN_CHK_EXPECTED_EN
            exp_addr_q    <= exp_addr_d;
`endif
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign err         = err_q;
    assign err_count   = err_count_q;
    assign err_dropped = err_dropped_q;
    assign led_addr    = led_addr_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;
endmodule

// File: tb/tb_m68k_freerun_checker.sv
// Scoreboard bench for m68k_freerun_checker: 24-bit instance for startup/report tests, 8-bit instance for wrap and reset abort.
module tb_m68k_freerun_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Instance A: 24-bit address, restart on error
    logic        rst_a, as_a, bus_rst_n_a, cpu_reset_a, err_a, err_dropped_a, new_tx_data_a, tx_busy_a;
    logic [23:0] addr_a;
    logic [15:0] err_count_a;
    logic [7:0]  led_addr_a, tx_data_a;
    logic        force_busy_a = 1'b0;
    int          busy_cnt_a = 0;
    int          err_pulses_a = 0;
    logic [7:0]  q_a [$];
    assign tx_busy_a = force_busy_a | (busy_cnt_a != 0);

    // Instance B: 8-bit address, single vector read, no restart
    logic        rst_b, as_b, bus_rst_n_b, cpu_reset_b, err_b, err_dropped_b, new_tx_data_b, tx_busy_b;
    logic [7:0]  addr_b;
    logic [15:0] err_count_b;
    logic [7:0]  led_addr_b, tx_data_b;
    int          busy_cnt_b = 0;
    int          err_pulses_b = 0;
    logic [7:0]  q_b [$];
    assign tx_busy_b = (busy_cnt_b != 0);

    m68k_freerun_checker #(.ADDR_W(24), .STRIDE(2), .SKIP_READS(4), .STARTUP_W(4), .RESTART_ON_ERR(1)) dut_a (
        .clk(clk), .rst(rst_a), .as_s(as_a), .addr_s(addr_a), .bus_rst_n(bus_rst_n_a),
        .cpu_reset(cpu_reset_a), .err(err_a), .err_count(err_count_a), .err_dropped(err_dropped_a),
        .led_addr(led_addr_a), .tx_data(tx_data_a), .new_tx_data(new_tx_data_a), .tx_busy(tx_busy_a));

    m68k_freerun_checker #(.ADDR_W(8), .STRIDE(2), .SKIP_READS(1), .STARTUP_W(4), .RESTART_ON_ERR(0)) dut_b (
        .clk(clk), .rst(rst_b), .as_s(as_b), .addr_s(addr_b), .bus_rst_n(bus_rst_n_b),
        .cpu_reset(cpu_reset_b), .err(err_b), .err_count(err_count_b), .err_dropped(err_dropped_b),
        .led_addr(led_addr_b), .tx_data(tx_data_b), .new_tx_data(new_tx_data_b), .tx_busy(tx_busy_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: pops expected bytes on each strobe and models the UART busy window
    always @(negedge clk) begin
        logic [7:0] want;
        if (new_tx_data_a) begin
            check("a_strobe_while_busy", tx_busy_a, 0);
            if (q_a.size() == 0) begin
                n_cmp++; n_mis++;
                $display("FAIL a_unexpected_byte: got 0x%0h, want no byte", tx_data_a);
            end else begin
                want = q_a.pop_front();
                check("a_tx_byte", tx_data_a, want);
            end
            busy_cnt_a = 4;
        end else if (busy_cnt_a > 0) begin
            busy_cnt_a--;
        end
        if (new_tx_data_b) begin
            check("b_strobe_while_busy", tx_busy_b, 0);
            if (q_b.size() == 0) begin
                n_cmp++; n_mis++;
                $display("FAIL b_unexpected_byte: got 0x%0h, want no byte", tx_data_b);
            end else begin
                want = q_b.pop_front();
                check("b_tx_byte", tx_data_b, want);
            end
            busy_cnt_b = 4;
        end else if (busy_cnt_b > 0) begin
            busy_cnt_b--;
        end
        if (err_a) err_pulses_a++;
        if (err_b) err_pulses_b++;
    end

    task automatic bus_a(input logic [23:0] a);
        as_a = 1'b1; addr_a = a;
        @(negedge clk);
        @(negedge clk);
        as_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_b(input logic [7:0] a);
        as_b = 1'b1; addr_b = a;
        @(negedge clk);
        @(negedge clk);
        as_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic prefix_a();
        bus_a(24'h0); bus_a(24'h2); bus_a(24'h4); bus_a(24'h6);
        for (int a = 0; a <= 'hC; a += 2) bus_a(24'(a));
    endtask

    task automatic push_frame_a(input logic [23:0] rx, input logic [23:0] ex);
        q_a.push_back(8'h45);
        q_a.push_back(rx[23:16]); q_a.push_back(rx[15:8]); q_a.push_back(rx[7:0]);
`ifdef FREERUN_CHK_EXPECTED_EN
        q_a.push_back(ex[23:16]); q_a.push_back(ex[15:8]); q_a.push_back(ex[7:0]);
`else
        if (ex == 24'hFFFFFF) q_a.push_back(8'hFF);
`endif
        q_a.push_back(8'h0A);
    endtask

    task automatic drain_a(input string name);
        int k;
        for (k = 0; k < 400 && q_a.size() != 0; k++) @(negedge clk);
        if (q_a.size() != 0) begin
            n_cmp++; n_mis++;
            $display("FAIL %s: got %0d bytes outstanding, want 0", name, q_a.size());
            q_a.delete();
        end
    endtask

    initial begin
        int cyc;
        int e0;
        int k;
        int total_b;
        rst_a = 1'b1; rst_b = 1'b1;
        as_a = 1'b0; as_b = 1'b0; addr_a = '0; addr_b = '0;
        bus_rst_n_a = 1'b0; bus_rst_n_b = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cpu_reset", cpu_reset_a, 1);
        check("rst_err", err_a, 0);
        check("rst_err_count", err_count_a, 0);
        check("rst_err_dropped", err_dropped_a, 0);
        check("rst_led_addr", led_addr_a, 0);
        check("rst_tx_data", tx_data_a, 0);
        check("rst_new_tx_data", new_tx_data_a, 0);

        // Startup delay: cpu_reset must fall on the 16th edge after release
        rst_a = 1'b0; rst_b = 1'b0;
        cyc = 0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            cyc++;
            if (!cpu_reset_a) break;
        end
        check("startup_cycles", cyc, 16);

        // Clean sequence: vector reads then linear walk to 0x20
        bus_rst_n_a = 1'b1;
        @(negedge clk);
        e0 = err_pulses_a;
        bus_a(24'h0); bus_a(24'h2); bus_a(24'h4); bus_a(24'h6);
        for (int a = 0; a <= 'h20; a += 2) bus_a(24'(a));
        check("clean_err_pulses", err_pulses_a - e0, 0);
        check("clean_err_count", err_count_a, 0);

        // Single mismatch: 0x10 where 0x0E is expected
        bus_rst_n_a = 1'b0; @(negedge clk);
        bus_rst_n_a = 1'b1; @(negedge clk);
        e0 = err_pulses_a;
        prefix_a();
        check("single_cpu_reset_pre", cpu_reset_a, 0);
        push_frame_a(24'h000010, 24'h00000E);
        as_a = 1'b1; addr_a = 24'h000010;
        @(negedge clk);
        check("single_err_latency", err_a, 1);
        @(negedge clk);
        check("single_restart", cpu_reset_a, 1);
        as_a = 1'b0;
        @(negedge clk);
        drain_a("single_frame_timeout");
        repeat (10) @(negedge clk);
        check("single_err_pulses", err_pulses_a - e0, 1);
        check("single_err_count", err_count_a, 1);
        check("single_err_dropped", err_dropped_a, 0);

        // Second mismatch while the first report is stalled by tx_busy
        rst_a = 1'b1; bus_rst_n_a = 1'b0; @(negedge clk);
        rst_a = 1'b0; bus_rst_n_a = 1'b1; @(negedge clk);
        check("drop_err_count_cleared", err_count_a, 0);
        e0 = err_pulses_a;
        force_busy_a = 1'b1;
        prefix_a();
        check("drop_cpu_reset_pre", cpu_reset_a, 0);
        push_frame_a(24'h000010, 24'h00000E);
        bus_a(24'h000010);
        bus_a(24'h000030);
        repeat (3) @(negedge clk);
        check("drop_err_count", err_count_a, 2);
        check("drop_err_dropped", err_dropped_a, 1);
        check("drop_restart", cpu_reset_a, 1);
        check("drop_no_byte_while_busy", q_a.size() > 0, 1);
        force_busy_a = 1'b0;
        drain_a("drop_frame_timeout");
        repeat (30) @(negedge clk);
        check("drop_err_pulses", err_pulses_a - e0, 2);

        // Wrap on the 8-bit instance: ... 0xFE, 0x00, 0x02 is legal
        bus_rst_n_b = 1'b1;
        @(negedge clk);
        e0 = err_pulses_b;
        bus_b(8'h00);
        for (int a = 0; a <= 'hFE; a += 2) bus_b(8'(a));
        check("wrap_led_fe", led_addr_b, 8'hFE);
        bus_b(8'h00);
        check("wrap_led_00", led_addr_b, 8'h00);
        bus_b(8'h02);
        check("wrap_err_pulses", err_pulses_b - e0, 0);
        check("wrap_err_count", err_count_b, 0);

        // Mismatch 0x55 where 0x04 is expected, then abort mid-frame with rst
        q_b.push_back(8'h45);
        q_b.push_back(8'h55);
`ifdef FREERUN_CHK_EXPECTED_EN
        q_b.push_back(8'h04);
`endif
        q_b.push_back(8'h0A);
        total_b = q_b.size();
        bus_b(8'h55);
        check("b_err_count", err_count_b, 1);
        for (k = 0; k < 200 && q_b.size() > total_b - 2; k++) @(negedge clk);
        check("b_two_bytes_sent", q_b.size(), total_b - 2);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_abort_new_tx_data", new_tx_data_b, 0);
        rst_b = 1'b0;
        q_b.delete();
        repeat (30) @(negedge clk);
        check("b_abort_err_count", err_count_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
